// File: rtl/frame_write_pkg.sv
// Shared types and constants for the frame writer: state codes, buffer-index
// width helper and the overrun counter saturation limit.
package frame_write_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ACK        = 4'd1,
    ST_CHECK_FIFO = 4'd2,
    ST_BURST      = 4'd3,
    ST_BURST_END  = 4'd4,
    ST_END        = 4'd5
  } state_t;

  localparam logic [15:0] OVERRUN_CNT_MAX = 16'hFFFF;

  // A single buffer still needs a 1-bit index port.
  function automatic int buf_idx_bits(input int num_buf);
    return (num_buf > 1) ? $clog2(num_buf) : 1;
  endfunction

endpackage

// File: rtl/sync_bit3.sv
// Three-flop synchroniser for a single asynchronous control bit.
module sync_bit3 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], i_d};
  end

  assign o_q = r_sync[2];

endmodule

// File: rtl/frame_write_ctrl.sv
// Frame writer: drains the pixel FIFO into rotating frame buffers in bursts.
// Optional overrun counter port enabled by FRAME_WRITE_OVERRUN_CNT_EN.
module frame_write_ctrl
  import frame_write_pkg::*;
#(
  parameter int                   ADDR_BITS     = 25,
  parameter int                   BURST_BITS    = 10,
  parameter int                   BURST_LEN     = 64,
  parameter int                   ADDR_INC      = 64,
  parameter int                   FIFO_CNT_BITS = 9,
  parameter int                   NUM_BUF       = 3,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR     = '0,
  parameter logic [ADDR_BITS-1:0] FRAME_STRIDE  = ADDR_BITS'(25'h0400000),
  localparam int                  BUF_BITS      = buf_idx_bits(NUM_BUF)
) (
  input  logic                     rst,
  input  logic                     mem_clk,
  input  logic                     write_req,
  output logic                     write_req_ack,
  input  logic [ADDR_BITS-1:0]     write_len,
  output logic                     write_finish,
  output logic                     wr_burst_req,
  output logic [BURST_BITS-1:0]    wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  input  logic                     wr_burst_finish,
  output logic                     fifo_aclr,
  input  logic [FIFO_CNT_BITS-1:0] rdusedw,
  output logic [BUF_BITS-1:0]      cur_buf_idx,
  output logic [BUF_BITS-1:0]      done_buf_idx,
  output logic                     frame_valid,
`ifdef FRAME_WRITE_OVERRUN_CNT_EN
  output logic [3:0]               write_state,
  output logic [15:0]              overrun_cnt
`else
  output logic [3:0]               write_state
`endif
);

  state_t                  r_state, w_state_nxt;
  logic                    w_req_s;
  logic [ADDR_BITS-1:0]    r_len_s1, r_len_s2;
  logic [ADDR_BITS-1:0]    r_len_latch;
  logic [ADDR_BITS-1:0]    r_write_cnt;
  logic [ADDR_BITS-1:0]    r_burst_addr;
  logic [BURST_BITS-1:0]   r_burst_len;
  logic                    r_burst_req;
  logic [BUF_BITS-1:0]     r_cur_buf, r_done_buf;
  logic                    r_frame_valid;
  logic [ADDR_BITS-1:0]    w_rem;
  logic [BURST_BITS-1:0]   w_blen;
  logic                    w_fifo_ok;
  logic [ADDR_BITS-1:0]    w_buf_base;
  logic [BUF_BITS-1:0]     w_cur_buf_nxt;
  logic                    w_unused_data_req;

  // The controller data strobe is not needed: the FIFO is read directly.
  assign w_unused_data_req = wr_burst_data_req;

  sync_bit3 u_req_sync (
    .i_clk (mem_clk),
    .i_rst (rst),
    .i_d   (write_req),
    .o_q   (w_req_s)
  );

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_len_s1 <= '0;
      r_len_s2 <= '0;
    end else begin
      r_len_s1 <= write_len;
      r_len_s2 <= r_len_s1;
    end
  end

  assign w_rem         = r_len_latch - r_write_cnt;
  assign w_blen        = (w_rem >= ADDR_BITS'(BURST_LEN)) ? BURST_BITS'(BURST_LEN)
                                                          : w_rem[BURST_BITS-1:0];
  assign w_fifo_ok     = 32'(rdusedw) >= 32'(w_blen);
  assign w_buf_base    = BASE_ADDR + ADDR_BITS'(r_cur_buf) * FRAME_STRIDE;
  assign w_cur_buf_nxt = (r_cur_buf == BUF_BITS'(NUM_BUF - 1)) ? '0 : r_cur_buf + 1'b1;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    write_req_ack = 1'b0;
    fifo_aclr     = 1'b0;
    write_finish  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_req_s) begin
          write_req_ack = 1'b1;
          fifo_aclr     = 1'b1;
        end else if (r_len_latch == '0) begin
          w_state_nxt = ST_END;
        end else begin
          w_state_nxt = ST_CHECK_FIFO;
        end
      end
      ST_CHECK_FIFO: begin
        if (w_req_s)        w_state_nxt = ST_ACK;
        else if (w_fifo_ok) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (wr_burst_finish) w_state_nxt = ST_BURST_END;
      end
      ST_BURST_END: begin
        if (w_req_s)                        w_state_nxt = ST_ACK;
        else if (r_write_cnt < r_len_latch) w_state_nxt = ST_CHECK_FIFO;
        else                                w_state_nxt = ST_END;
      end
      ST_END: begin
        write_finish = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Overrun re-enters ACK without passing END, so buffer indices stay put.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_len_latch   <= '0;
      r_write_cnt   <= '0;
      r_burst_addr  <= '0;
      r_burst_len   <= '0;
      r_burst_req   <= 1'b0;
      r_cur_buf     <= '0;
      r_done_buf    <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACK: begin
          if (w_req_s) begin
            r_len_latch  <= r_len_s2;
            r_burst_addr <= w_buf_base;
            r_write_cnt  <= '0;
          end
        end
        ST_CHECK_FIFO: begin
          if (!w_req_s && w_fifo_ok) begin
            r_burst_len <= w_blen;
            r_burst_req <= 1'b1;
          end
        end
        ST_BURST: begin
          if (wr_burst_finish) begin
            r_burst_req  <= 1'b0;
            r_write_cnt  <= r_write_cnt + ADDR_BITS'(r_burst_len);
            r_burst_addr <= r_burst_addr + ADDR_BITS'(r_burst_len) * ADDR_BITS'(ADDR_INC);
          end
        end
        ST_END: begin
          r_done_buf    <= r_cur_buf;
          r_frame_valid <= 1'b1;
          r_cur_buf     <= w_cur_buf_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_WRITE_OVERRUN_CNT_EN
  logic        w_overrun_evt;
  logic [15:0] r_overrun_cnt;

  assign w_overrun_evt = w_req_s && ((r_state == ST_CHECK_FIFO) || (r_state == ST_BURST_END));

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst)
      r_overrun_cnt <= '0;
    else if (w_overrun_evt && (r_overrun_cnt != OVERRUN_CNT_MAX))
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign wr_burst_req  = r_burst_req;
  assign wr_burst_len  = r_burst_len;
  assign wr_burst_addr = r_burst_addr;
  assign cur_buf_idx   = r_cur_buf;
  assign done_buf_idx  = r_done_buf;
  assign frame_valid   = r_frame_valid;
  assign write_state   = r_state;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl with a simple burst-controller responder.
// Also checks overrun_cnt when FRAME_WRITE_OVERRUN_CNT_EN is defined.
module tb_frame_write_ctrl;

  localparam int CTL_LAT = 6;

  logic        rst, mem_clk, write_req, write_req_ack, write_finish;
  logic [24:0] write_len, wr_burst_addr;
  logic        wr_burst_req, wr_burst_data_req, wr_burst_finish, fifo_aclr, frame_valid;
  logic [9:0]  wr_burst_len;
  logic [8:0]  rdusedw;
  logic [1:0]  cur_buf_idx, done_buf_idx;
  logic [3:0]  write_state;
`ifdef FRAME_WRITE_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit ctl_en = 0;
  bit ctl_active;
  int ctl_wait;
  logic [24:0] q_addr[$];
  logic [9:0]  q_len[$];

  frame_write_ctrl dut (
    .rst               (rst),
    .mem_clk           (mem_clk),
    .write_req         (write_req),
    .write_req_ack     (write_req_ack),
    .write_len         (write_len),
    .write_finish      (write_finish),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_data_req (wr_burst_data_req),
    .wr_burst_finish   (wr_burst_finish),
    .fifo_aclr         (fifo_aclr),
    .rdusedw           (rdusedw),
    .cur_buf_idx       (cur_buf_idx),
    .done_buf_idx      (done_buf_idx),
    .frame_valid       (frame_valid),
`ifdef FRAME_WRITE_OVERRUN_CNT_EN
    .write_state       (write_state),
    .overrun_cnt       (overrun_cnt)
`else
    .write_state       (write_state)
`endif
  );

  initial begin
    mem_clk = 0;
    forever #5 mem_clk = ~mem_clk;
  end

  // Memory controller model: logs each burst, finishes it CTL_LAT cycles later.
  initial begin
    wr_burst_finish = 0;
    ctl_active = 0;
    ctl_wait = 0;
    forever begin
      @(negedge mem_clk);
      wr_burst_finish = 0;
      if (rst) ctl_active = 0;
      else if (ctl_en && wr_burst_req) begin
        if (!ctl_active) begin
          ctl_active = 1;
          ctl_wait = CTL_LAT;
          q_addr.push_back(wr_burst_addr);
          q_len.push_back(wr_burst_len);
        end else if (ctl_wait > 1) ctl_wait--;
        else begin
          wr_burst_finish = 1;
          ctl_active = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic request_frame(input logic [24:0] len, output bit ok);
    ok = 0;
    write_len = len;
    write_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (write_req_ack) begin ok = 1; break; end
    end
    write_req = 0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (!write_req_ack) begin ok = 1; break; end
      end
    end
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (write_finish) begin ok = 1; break; end
    end
  endtask

  task automatic wait_bursts(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (q_addr.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; write_req = 0; write_len = 0; rdusedw = 0; wr_burst_data_req = 0;
    repeat (3) tick();
    checks++;
    if ({write_req_ack, write_finish, wr_burst_req, fifo_aclr, frame_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {write_req_ack, write_finish, wr_burst_req, fifo_aclr, frame_valid});
    end
    checks++;
    if ({wr_burst_addr, wr_burst_len, cur_buf_idx, done_buf_idx, write_state} !== '0) begin
      errors++; $display("FAIL reset_values: addr=%0h len=%0d cur=%0d done=%0d st=%0d expected all 0",
                         wr_burst_addr, wr_burst_len, cur_buf_idx, done_buf_idx, write_state);
    end
`ifdef FRAME_WRITE_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_overrun_cnt: got %0d expected 0", overrun_cnt);
    end
`endif
    rst = 0;
    repeat (2) tick();
  endtask

  task automatic test_frame_256();
    bit ok;
    write_len = 256; rdusedw = 100; ctl_en = 1;
    q_addr.delete(); q_len.delete();
    repeat (3) tick();
    write_req = 1;
    repeat (3) tick();
    checks++;
    if (write_req_ack !== 1'b0) begin
      errors++; $display("FAIL ack_rise_early: got %b expected 0", write_req_ack);
    end
    tick();
    checks++;
    if ({write_req_ack, fifo_aclr} !== 2'b11) begin
      errors++; $display("FAIL ack_rise_4cyc: got ack/aclr=%b expected 11", {write_req_ack, fifo_aclr});
    end
    write_req = 0;
    repeat (2) tick();
    checks++;
    if (write_req_ack !== 1'b1) begin
      errors++; $display("FAIL ack_fall_early: got %b expected 1", write_req_ack);
    end
    tick();
    checks++;
    if (write_req_ack !== 1'b0) begin
      errors++; $display("FAIL ack_fall_3cyc: got %b expected 0", write_req_ack);
    end
    wait_finish(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL f256_finish: got timeout expected write_finish"); end
    checks++;
    if (q_addr.size() !== 4) begin
      errors++; $display("FAIL f256_burst_count: got %0d expected 4", q_addr.size());
    end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 25'(i * 4096) || q_len[i] !== 10'd64) begin
        errors++; $display("FAIL f256_burst%0d: got addr=%0h len=%0d expected addr=%0h len=64",
                           i, q_addr[i], q_len[i], i * 4096);
      end
    end
    tick();
    checks++;
    if ({write_finish, frame_valid, done_buf_idx, cur_buf_idx} !== {1'b0, 1'b1, 2'd0, 2'd1}) begin
      errors++; $display("FAIL f256_post: got fin=%b valid=%b done=%0d cur=%0d expected 0 1 0 1",
                         write_finish, frame_valid, done_buf_idx, cur_buf_idx);
    end
  endtask

  task automatic test_short_tail();
    bit ok;
    logic [24:0] exp_addr[3];
    logic [9:0]  exp_len[3];
    exp_addr = '{25'h400000, 25'h401000, 25'h402000};
    exp_len  = '{10'd64, 10'd64, 10'd22};
    q_addr.delete(); q_len.delete();
    rdusedw = 100;
    request_frame(150, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tail_handshake: got timeout expected ack"); end
    wait_bursts(2, 200, ok);
    rdusedw = 21;
    repeat (30) tick();
    checks++;
    if (q_addr.size() !== 2 || wr_burst_req !== 1'b0 || write_state !== 4'd2) begin
      errors++; $display("FAIL tail_stall21: got bursts=%0d req=%b st=%0d expected 2 0 2",
                         q_addr.size(), wr_burst_req, write_state);
    end
    rdusedw = 22;
    tick();
    checks++;
    if (wr_burst_req !== 1'b1) begin
      errors++; $display("FAIL tail_go22: got req=%b expected 1", wr_burst_req);
    end
    wait_finish(200, ok);
    checks++;
    if (!ok || q_addr.size() !== 3) begin
      errors++; $display("FAIL tail_finish: got ok=%b bursts=%0d expected 1 3", ok, q_addr.size());
    end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== exp_addr[i] || q_len[i] !== exp_len[i]) begin
        errors++; $display("FAIL tail_burst%0d: got addr=%0h len=%0d expected addr=%0h len=%0d",
                           i, q_addr[i], q_len[i], exp_addr[i], exp_len[i]);
      end
    end
    tick();
    checks++;
    if ({done_buf_idx, cur_buf_idx} !== {2'd1, 2'd2}) begin
      errors++; $display("FAIL tail_bufidx: got done=%0d cur=%0d expected 1 2", done_buf_idx, cur_buf_idx);
    end
  endtask

  task automatic test_fifo_threshold();
    bit ok;
    q_addr.delete(); q_len.delete();
    rdusedw = 63;
    request_frame(64, ok);
    repeat (20) tick();
    checks++;
    if (!ok || wr_burst_req !== 1'b0 || q_addr.size() !== 0 || write_state !== 4'd2) begin
      errors++; $display("FAIL thr_63: got ok=%b req=%b bursts=%0d st=%0d expected 1 0 0 2",
                         ok, wr_burst_req, q_addr.size(), write_state);
    end
    rdusedw = 64;
    tick();
    checks++;
    if (wr_burst_req !== 1'b1) begin
      errors++; $display("FAIL thr_64: got req=%b expected 1", wr_burst_req);
    end
    wait_finish(200, ok);
    checks++;
    if (!ok || q_addr.size() !== 1 || q_addr[0] !== 25'h800000 || q_len[0] !== 10'd64) begin
      errors++; $display("FAIL thr_burst: got ok=%b n=%0d addr=%0h expected 1 1 800000",
                         ok, q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 25'h0);
    end
    tick();
    checks++;
    if ({done_buf_idx, cur_buf_idx} !== {2'd2, 2'd0}) begin
      errors++; $display("FAIL thr_bufidx: got done=%0d cur=%0d expected 2 0", done_buf_idx, cur_buf_idx);
    end
  endtask

  task automatic test_rotation_wrap();
    bit ok;
    q_addr.delete(); q_len.delete();
    rdusedw = 100;
    request_frame(128, ok);
    wait_finish(300, ok);
    checks++;
    if (!ok || q_addr.size() !== 2 || q_addr[0] !== 25'h0 || q_addr[1] !== 25'h1000) begin
      errors++; $display("FAIL wrap_bursts: got ok=%b n=%0d addr0=%0h expected 1 2 0",
                         ok, q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 25'h1);
    end
    tick();
    checks++;
    if ({done_buf_idx, cur_buf_idx, frame_valid} !== {2'd0, 2'd1, 1'b1}) begin
      errors++; $display("FAIL wrap_bufidx: got done=%0d cur=%0d valid=%b expected 0 1 1",
                         done_buf_idx, cur_buf_idx, frame_valid);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    q_addr.delete(); q_len.delete();
    rdusedw = 100;
    request_frame(256, ok);
    wait_bursts(2, 200, ok);
    write_req = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (write_req_ack) begin ok = 1; break; end
    end
    checks++;
    if (!ok || write_state !== 4'd1 || done_buf_idx !== 2'd0 || cur_buf_idx !== 2'd1) begin
      errors++; $display("FAIL ovr_reack: got ok=%b st=%0d done=%0d cur=%0d expected 1 1 0 1",
                         ok, write_state, done_buf_idx, cur_buf_idx);
    end
`ifdef FRAME_WRITE_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 16'd1) begin
      errors++; $display("FAIL ovr_cnt: got %0d expected 1", overrun_cnt);
    end
`endif
    write_req = 0;
    wait_finish(600, ok);
    checks++;
    if (!ok || q_addr.size() !== 6) begin
      errors++; $display("FAIL ovr_finish: got ok=%b bursts=%0d expected 1 6", ok, q_addr.size());
    end
    checks++;
    if (q_addr.size() == 6 && (q_addr[1] !== 25'h401000 || q_addr[2] !== 25'h400000 ||
                               q_addr[5] !== 25'h403000)) begin
      errors++; $display("FAIL ovr_addrs: got %0h %0h %0h expected 401000 400000 403000",
                         q_addr[1], q_addr[2], q_addr[5]);
    end
    tick();
    checks++;
    if ({done_buf_idx, cur_buf_idx} !== {2'd1, 2'd2}) begin
      errors++; $display("FAIL ovr_bufidx: got done=%0d cur=%0d expected 1 2", done_buf_idx, cur_buf_idx);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    q_addr.delete(); q_len.delete();
    request_frame(0, ok);
    wait_finish(20, ok);
    checks++;
    if (!ok || q_addr.size() !== 0) begin
      errors++; $display("FAIL zero_len: got ok=%b bursts=%0d expected 1 0", ok, q_addr.size());
    end
    tick();
    checks++;
    if ({write_finish, done_buf_idx, cur_buf_idx} !== {1'b0, 2'd2, 2'd0}) begin
      errors++; $display("FAIL zero_post: got fin=%b done=%0d cur=%0d expected 0 2 0",
                         write_finish, done_buf_idx, cur_buf_idx);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    ctl_en = 0;
    rdusedw = 100;
    request_frame(64, ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_burst_req) begin ok = 1; break; end
    end
    checks++;
    if (!ok || write_state !== 4'd3) begin
      errors++; $display("FAIL rstb_inburst: got ok=%b st=%0d expected 1 3", ok, write_state);
    end
    @(negedge mem_clk);
    rst = 1;
    #1;
    checks++;
    if ({wr_burst_req, write_req_ack, write_finish, fifo_aclr, frame_valid} !== 5'b0 ||
        {wr_burst_addr, wr_burst_len, cur_buf_idx, done_buf_idx, write_state} !== '0) begin
      errors++; $display("FAIL rstb_clear: got req=%b valid=%b st=%0d addr=%0h cur=%0d expected all 0",
                         wr_burst_req, frame_valid, write_state, wr_burst_addr, cur_buf_idx);
    end
    repeat (2) tick();
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_256();
    test_short_tail();
    test_fifo_threshold();
    test_rotation_wrap();
    test_overrun();
    test_zero_len();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
